// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter: owns the SDRAM command bus. Mirrors the init FSM until init
// completes, then grants the bus to one of NUM_CLIENTS requesters at a time and
// injects PRECHARGE-ALL + AUTO-REFRESH every REF_INTERVAL cycles.
module sdram_bus_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 3,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned BA_W         = 2,
    parameter int unsigned DQ_W         = 16,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned REF_INTERVAL = 1037,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 9
) (
    input  logic                          clk_133,
    input  logic                          reset_n,
    input  logic                          init_done,
    input  logic [3:0]                    init_cmd,
    input  logic [ADDR_W-1:0]             init_addr,
    input  logic [BA_W-1:0]               init_ba,
    input  logic                          init_cke,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    output logic [NUM_CLIENTS-1:0]        cl_grant,
    input  logic [4*NUM_CLIENTS-1:0]      cl_cmd,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_addr,
    input  logic [BA_W*NUM_CLIENTS-1:0]   cl_ba,
    input  logic [DQ_W*NUM_CLIENTS-1:0]   cl_dq_out,
    input  logic [NUM_CLIENTS-1:0]        cl_dq_oe,
    output logic                          cs_n,
    output logic                          ras_n,
    output logic                          cas_n,
    output logic                          we_n,
    output logic [ADDR_W-1:0]             addr,
    output logic [BA_W-1:0]               ba,
    output logic                          cke,
    output logic [DQ_W-1:0]               dq_out,
    output logic                          dq_oe,
    output logic                          refresh_busy,
    output logic                          refresh_overrun
);

    localparam int unsigned IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned REF_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int unsigned T_MAX  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned WAIT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_GRANT,
        ST_REF_PRE,
        ST_REF_WAIT_RP,
        ST_REF_AR,
        ST_REF_WAIT_RFC
    } state_t;

    state_t                   state, state_nxt;
    logic [NUM_CLIENTS-1:0]   grant_nxt;
    logic [IDX_W-1:0]         grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [WAIT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic [REF_W-1:0]         ref_cnt, ref_cnt_nxt;
    logic                     refresh_due, refresh_due_nxt;
    logic                     overrun_nxt;
    logic                     due_clr;
    logic                     ref_wrap;
    logic                     win_found;
    logic [IDX_W-1:0]         win_idx;

    // Candidate client for search slot 'off': plain index, or rotated from rr_ptr.
    function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] ptr,
                                                  input int unsigned off);
        int unsigned sum;
        sum = off;
        if (ARB_MODE == 1) sum = 32'(ptr) + off;
        if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
        return IDX_W'(sum);
    endfunction

    // Winner search: scan from last to first slot so the first requesting slot wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (cl_req[cand_idx(rr_ptr, NUM_CLIENTS - 1 - i)]) begin
                win_found = 1'b1;
                win_idx   = cand_idx(rr_ptr, NUM_CLIENTS - 1 - i);
            end
        end
    end

    // Next-state logic for bus ownership and the refresh sequence.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = cl_grant;
        grant_idx_nxt = grant_idx;
        rr_ptr_nxt    = rr_ptr;
        wait_cnt_nxt  = wait_cnt;
        due_clr       = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_done) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (refresh_due) begin
                    state_nxt = ST_REF_PRE;
                end else if (win_found) begin
                    state_nxt     = ST_GRANT;
                    grant_nxt     = NUM_CLIENTS'(1) << win_idx;
                    grant_idx_nxt = win_idx;
                    if (ARB_MODE == 1)
                        rr_ptr_nxt = (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!cl_req[grant_idx]) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
            ST_REF_PRE: begin
                state_nxt    = ST_REF_WAIT_RP;
                wait_cnt_nxt = '0;
            end
            ST_REF_WAIT_RP: begin
                if (wait_cnt == WAIT_W'(T_RP - 1)) begin
                    state_nxt = ST_REF_AR;
                    due_clr   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ST_REF_AR: begin
                state_nxt    = ST_REF_WAIT_RFC;
                wait_cnt_nxt = '0;
            end
            ST_REF_WAIT_RFC: begin
                if (wait_cnt == WAIT_W'(T_RFC - 1)) state_nxt = ST_IDLE;
                else                                wait_cnt_nxt = wait_cnt + 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Refresh interval timer; a wrap while a refresh is still pending is an overrun.
    always_comb begin
        ref_cnt_nxt     = ref_cnt;
        refresh_due_nxt = refresh_due;
        overrun_nxt     = refresh_overrun;
        ref_wrap        = (state != ST_INIT) && (ref_cnt == REF_W'(REF_INTERVAL - 1));
        if (state != ST_INIT) ref_cnt_nxt = ref_wrap ? '0 : ref_cnt + 1'b1;
        if (ref_wrap) begin
            refresh_due_nxt = 1'b1;
            if (refresh_due) overrun_nxt = 1'b1;
        end else if (due_clr) begin
            refresh_due_nxt = 1'b0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk_133 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_INIT;
            cl_grant        <= '0;
            grant_idx       <= '0;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            ref_cnt         <= '0;
            refresh_due     <= 1'b0;
            refresh_overrun <= 1'b0;
        end else begin
            state           <= state_nxt;
            cl_grant        <= grant_nxt;
            grant_idx       <= grant_idx_nxt;
            rr_ptr          <= rr_ptr_nxt;
            wait_cnt        <= wait_cnt_nxt;
            ref_cnt         <= ref_cnt_nxt;
            refresh_due     <= refresh_due_nxt;
            refresh_overrun <= overrun_nxt;
        end
    end

    // Pin mux driven from the registered state and owner index.
    always_comb begin
        {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
        addr   = '0;
        ba     = '0;
        cke    = 1'b1;
        dq_out = '0;
        dq_oe  = 1'b0;
        case (state)
            ST_INIT: begin
                {cs_n, ras_n, cas_n, we_n} = init_cmd;
                addr = init_addr;
                ba   = init_ba;
                cke  = init_cke;
            end
            ST_GRANT: begin
                {cs_n, ras_n, cas_n, we_n} = cl_cmd[grant_idx*4 +: 4];
                addr   = cl_addr[grant_idx*ADDR_W +: ADDR_W];
                ba     = cl_ba[grant_idx*BA_W +: BA_W];
                dq_out = cl_dq_out[grant_idx*DQ_W +: DQ_W];
                dq_oe  = cl_dq_oe[grant_idx];
            end
            ST_REF_PRE: begin
                {cs_n, ras_n, cas_n, we_n} = CMD_PRE;
                addr[10] = 1'b1;
            end
            ST_REF_AR: begin
                {cs_n, ras_n, cas_n, we_n} = CMD_REF;
            end
            default: ;
        endcase
    end

    // Busy flag covers the whole precharge/refresh sequence.
    always_comb begin
        refresh_busy = (state == ST_REF_PRE) || (state == ST_REF_WAIT_RP) ||
                       (state == ST_REF_AR)  || (state == ST_REF_WAIT_RFC);
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Scoreboard bench for sdram_bus_arbiter: dut0 in fixed-priority mode, dut1 in
// round-robin mode. Expected pin/grant events are queued ahead of time and popped
// by negedge monitors whenever the observed bus state changes.
`timescale 1ns/1ps
module tb_sdram_bus_arbiter;

    localparam int unsigned NC = 3;

    typedef struct packed {
        logic [39:0] obs;
        logic [31:0] gap;
    } ev_t;

    logic clk_133 = 1'b0;
    logic reset_n;
    logic init_done;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic [1:0]  init_ba;
    logic        init_cke;
    logic [2:0]  req0, req1;
    logic [11:0] cl_cmd;
    logic [35:0] cl_addr;
    logic [5:0]  cl_ba;
    logic [47:0] cl_dq_out;
    logic [2:0]  cl_dq_oe;

    logic [2:0]  d0_grant, d1_grant;
    logic d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n, d0_cke, d0_oe, d0_busy, d0_ovr;
    logic d1_cs_n, d1_ras_n, d1_cas_n, d1_we_n, d1_cke, d1_oe, d1_busy, d1_ovr;
    logic [11:0] d0_addr, d1_addr;
    logic [1:0]  d0_ba, d1_ba;
    logic [15:0] d0_dq, d1_dq;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int e0    = 0;

    ev_t         q0[$];
    logic [2:0]  q1[$];
    ev_t         ev;
    logic [2:0]  exp1;
    logic        mon0_en = 1'b0;
    logic        mon1_en = 1'b0;
    logic [39:0] last0;
    int          last0_cyc;
    logic [2:0]  last1;

    sdram_bus_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(12), .BA_W(2), .DQ_W(16), .ARB_MODE(0),
                        .REF_INTERVAL(1037), .T_RP(3), .T_RFC(9)) dut0 (
        .clk_133(clk_133), .reset_n(reset_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba), .init_cke(init_cke),
        .cl_req(req0), .cl_grant(d0_grant), .cl_cmd(cl_cmd), .cl_addr(cl_addr),
        .cl_ba(cl_ba), .cl_dq_out(cl_dq_out), .cl_dq_oe(cl_dq_oe),
        .cs_n(d0_cs_n), .ras_n(d0_ras_n), .cas_n(d0_cas_n), .we_n(d0_we_n),
        .addr(d0_addr), .ba(d0_ba), .cke(d0_cke), .dq_out(d0_dq), .dq_oe(d0_oe),
        .refresh_busy(d0_busy), .refresh_overrun(d0_ovr));

    sdram_bus_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(12), .BA_W(2), .DQ_W(16), .ARB_MODE(1),
                        .REF_INTERVAL(1037), .T_RP(3), .T_RFC(9)) dut1 (
        .clk_133(clk_133), .reset_n(reset_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba), .init_cke(init_cke),
        .cl_req(req1), .cl_grant(d1_grant), .cl_cmd(cl_cmd), .cl_addr(cl_addr),
        .cl_ba(cl_ba), .cl_dq_out(cl_dq_out), .cl_dq_oe(cl_dq_oe),
        .cs_n(d1_cs_n), .ras_n(d1_ras_n), .cas_n(d1_cas_n), .we_n(d1_we_n),
        .addr(d1_addr), .ba(d1_ba), .cke(d1_cke), .dq_out(d1_dq), .dq_oe(d1_oe),
        .refresh_busy(d1_busy), .refresh_overrun(d1_ovr));

    always #4 clk_133 = ~clk_133;

    always @(posedge clk_133) cyc <= cyc + 1;

    logic [39:0] d0_obs;
    assign d0_obs = {d0_ovr, d0_grant, d0_busy, d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n,
                     d0_ba, d0_addr, d0_oe, d0_dq};

    function automatic logic [39:0] mk(input logic ovr, input logic [2:0] g, input logic busy,
                                       input logic [3:0] cmd, input logic [1:0] b,
                                       input logic [11:0] a, input logic oe, input logic [15:0] dq);
        return {ovr, g, busy, cmd, b, a, oe, dq};
    endfunction

    function automatic logic [39:0] idle_o(input logic ovr);
        return mk(ovr, 3'b000, 1'b0, 4'b0111, 2'd0, 12'h000, 1'b0, 16'h0000);
    endfunction

    // Client bus values are the constants driven below, hand-expanded per owner.
    function automatic logic [39:0] grant_o(input int c, input logic ovr);
        case (c)
            0:       return mk(ovr, 3'b001, 1'b0, 4'b0100, 2'd1, 12'h111, 1'b1, 16'hA000);
            1:       return mk(ovr, 3'b010, 1'b0, 4'b0101, 2'd2, 12'h222, 1'b0, 16'hB001);
            default: return mk(ovr, 3'b100, 1'b0, 4'b0011, 2'd3, 12'h333, 1'b1, 16'hC002);
        endcase
    endfunction

    task automatic push0(input logic [39:0] o, input int g);
        q0.push_back({o, 32'(g)});
    endtask

    // PRE(addr10) -> 3 NOP -> AUTO REFRESH -> 9 NOP -> idle
    task automatic push_ref(input int first_gap, input logic ovr);
        push0(mk(ovr, 3'b000, 1'b1, 4'b0010, 2'd0, 12'h400, 1'b0, 16'h0), first_gap);
        push0(mk(ovr, 3'b000, 1'b1, 4'b0111, 2'd0, 12'h000, 1'b0, 16'h0), 1);
        push0(mk(ovr, 3'b000, 1'b1, 4'b0001, 2'd0, 12'h000, 1'b0, 16'h0), 3);
        push0(mk(ovr, 3'b000, 1'b1, 4'b0111, 2'd0, 12'h000, 1'b0, 16'h0), 1);
        push0(idle_o(ovr), 9);
    endtask

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic goto(input int n);
        while (cyc - e0 < n) @(negedge clk_133);
    endtask

    task automatic wait_g1(input logic [2:0] want);
        int t;
        t = 0;
        while (d1_grant !== want && t < 40) begin
            @(negedge clk_133);
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_wait: grant %b never reached %b", d1_grant, want);
        end
    endtask

    // dut0 monitor: every change of the observed bus tuple is one scoreboard event.
    always @(negedge clk_133) begin
        if (mon0_en && (d0_obs !== last0)) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ev0_extra: got %h at rel %0d want no event", d0_obs, cyc - e0);
            end else begin
                ev = q0.pop_front();
                chk("ev0_obs", d0_obs, ev.obs);
                chk("ev0_gap", 40'(cyc - last0_cyc), 40'(ev.gap));
            end
            last0     = d0_obs;
            last0_cyc = cyc;
        end
    end

    // dut1 monitor: grant sequence only.
    always @(negedge clk_133) begin
        if (mon1_en && (d1_grant !== last1)) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ev1_extra: got %b want no event", d1_grant);
            end else begin
                exp1 = q1.pop_front();
                chk("ev1_grant", 40'(d1_grant), 40'(exp1));
            end
            last1 = d1_grant;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        init_done = 1'b0;
        init_cmd  = 4'b1111;
        init_addr = '0;
        init_ba   = '0;
        init_cke  = 1'b0;
        req0      = '0;
        req1      = '0;
        cl_cmd    = {4'b0011, 4'b0101, 4'b0100};
        cl_addr   = {12'h333, 12'h222, 12'h111};
        cl_ba     = {2'd3, 2'd2, 2'd1};
        cl_dq_out = {16'hC002, 16'hB001, 16'hA000};
        cl_dq_oe  = 3'b101;

        repeat (3) @(negedge clk_133);
        chk("rst_flags0", 40'({d0_grant, d0_busy, d0_ovr}), 40'd0);
        chk("rst_grant1", 40'(d1_grant), 40'd0);
        reset_n = 1'b1;

        // init_done low: pins mirror the init bus, no grant.
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_133);
            init_cmd  = 4'(k);
            init_addr = 12'(k * 37 + 5);
            init_ba   = 2'(k);
            init_cke  = 1'(k);
            req0      = (k > 20) ? 3'b111 : 3'b000;
            #1;
            if (k % 10 == 5 || k == 49)
                chk("init_mirror",
                    40'({d0_grant, d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n, d0_addr, d0_ba,
                         d0_cke, d0_oe, d0_busy}),
                    40'({3'b000, init_cmd, init_addr, init_ba, init_cke, 1'b0, 1'b0}));
        end
        req0      = 3'b000;
        init_done = 1'b1;
        e0        = cyc + 1;
        @(negedge clk_133);
        chk("idle_pins", d0_obs, idle_o(1'b0));
        chk("idle_cke", 40'(d0_cke), 40'd1);
        last0     = idle_o(1'b0);
        last0_cyc = cyc;
        mon0_en   = 1'b1;
        last1     = 3'b000;
        mon1_en   = 1'b1;

        fork
            begin : t_main
                // fixed priority: 110 -> client 1, then one NOP, then client 2
                push0(grant_o(1, 1'b0), 1);
                req0 = 3'b110;
                push0(idle_o(1'b0), 10);
                push0(grant_o(2, 1'b0), 1);
                goto(10);
                req0 = 3'b100;
                push0(idle_o(1'b0), 9);
                goto(20);
                req0 = 3'b000;
                // idle refreshes every 1037 cycles; third one collides with req[0]
                push_ref(1017, 1'b0);
                push_ref(1023, 1'b0);
                push_ref(1023, 1'b0);
                push0(grant_o(0, 1'b0), 1);
                goto(3111);
                req0 = 3'b001;
                // client 0 holds across two wraps -> sticky overrun
                push0(grant_o(0, 1'b1), 2058);
                push0(idle_o(1'b1), 6);
                push_ref(1, 1'b1);
                goto(5190);
                req0 = 3'b000;
                goto(5215);
                chk("q0_drained", 40'(q0.size()), 40'd0);
                mon0_en = 1'b0;
                mon1_en = 1'b0;
                chk("ovr_before_rst", 40'(d0_ovr), 40'd1);
                // async reset mid-run: back to INIT, overrun cleared
                reset_n = 1'b0;
                #1;
                chk("rst2_flags0", 40'({d0_grant, d0_busy, d0_ovr}), 40'd0);
                chk("rst2_mirror",
                    40'({d0_cs_n, d0_ras_n, d0_cas_n, d0_we_n, d0_addr, d0_ba, d0_cke, d0_oe}),
                    40'({init_cmd, init_addr, init_ba, init_cke, 1'b0}));
                chk("rst2_grant1", 40'(d1_grant), 40'd0);
                @(negedge clk_133);
                reset_n = 1'b1;
                @(negedge clk_133);
                chk("rst2_ovr_hold", 40'(d0_ovr), 40'd0);
            end
            begin : t_rr
                logic [2:0] cur, nxt;
                goto(30);
                q1.push_back(3'b001);
                req1 = 3'b111;
                for (int o = 0; o < 3; o++) begin
                    cur = 3'b001 << o;
                    nxt = 3'b001 << ((o + 1) % 3);
                    wait_g1(cur);
                    repeat (5) @(negedge clk_133);
                    q1.push_back(3'b000);
                    q1.push_back(nxt);
                    req1[o] = 1'b0;
                    repeat (2) @(negedge clk_133);
                    req1[o] = 1'b1;
                end
                wait_g1(3'b001);
                repeat (3) @(negedge clk_133);
                q1.push_back(3'b000);
                req1 = 3'b000;
                repeat (5) @(negedge clk_133);
            end
        join

        chk("q1_drained", 40'(q1.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
